// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and the
// request record used both for the CPU pending slot and the memory port.
package mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 27;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CPU,
    ARB_BG
  } arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic                  rnw;
    logic [7:0]            wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the external memory port between the CPU (priority) and a
// background requester, with a bounded-starvation guarantee for the latter.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = ARB_ADDR_W,
  parameter int BG_MAX_WAIT = 4,
  parameter int CNT_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rnw,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_wait,
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  input  logic              bg_rnw,
  input  logic [7:0]        bg_wdata,
  output logic              bg_ack,
  output logic [7:0]        bg_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rnw,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(BG_MAX_WAIT);

  arb_state_t       state_reg;
  mem_req_t         pend_reg;
  logic             cpu_pend_reg;
  logic [CNT_W-1:0] starve_cnt_reg;
  mem_req_t         mem_reg;
  logic             mem_req_reg;
  logic [7:0]       cpu_rdata_reg;
  logic [7:0]       bg_rdata_reg;
  logic             bg_ack_reg;

  mem_req_t cpu_sel;
  mem_req_t bg_sel;
  logic     cpu_avail;
  logic     bg_force;

  // A fresh strobe in IDLE is granted on its own edge, bypassing the pending slot.
  always_comb begin
    cpu_sel   = cpu_pend_reg ? pend_reg : '{addr: cpu_addr, rnw: cpu_rnw, wdata: cpu_wdata};
    bg_sel    = '{addr: bg_addr, rnw: bg_rnw, wdata: bg_wdata};
    cpu_avail = cpu_pend_reg | cpu_req;
    bg_force  = bg_req && (starve_cnt_reg == MAX_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ARB_IDLE;
      pend_reg       <= '0;
      cpu_pend_reg   <= 1'b0;
      starve_cnt_reg <= '0;
      mem_reg        <= '0;
      mem_req_reg    <= 1'b0;
      cpu_rdata_reg  <= '0;
      bg_rdata_reg   <= '0;
      bg_ack_reg     <= 1'b0;
    end else begin
      bg_ack_reg <= 1'b0;

      // One-deep capture; a strobe while already pending is dropped.
      if (cpu_req && !cpu_pend_reg) begin
        cpu_pend_reg <= 1'b1;
        pend_reg     <= '{addr: cpu_addr, rnw: cpu_rnw, wdata: cpu_wdata};
      end

      case (state_reg)
        ARB_IDLE: begin
          if (cpu_avail && !bg_force) begin
            state_reg   <= ARB_CPU;
            mem_req_reg <= 1'b1;
            mem_reg     <= cpu_sel;
            if (!bg_req)
              starve_cnt_reg <= '0;
            else if (starve_cnt_reg != MAX_CNT)
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
          end else if (bg_req) begin
            state_reg      <= ARB_BG;
            mem_req_reg    <= 1'b1;
            mem_reg        <= bg_sel;
            starve_cnt_reg <= '0;
          end else begin
            starve_cnt_reg <= '0;
          end
        end
        ARB_CPU: begin
          if (mem_ack) begin
            state_reg    <= ARB_IDLE;
            mem_req_reg  <= 1'b0;
            cpu_pend_reg <= 1'b0;
            if (mem_reg.rnw)
              cpu_rdata_reg <= mem_rdata;
          end
        end
        ARB_BG: begin
          if (mem_ack) begin
            state_reg    <= ARB_IDLE;
            mem_req_reg  <= 1'b0;
            bg_rdata_reg <= mem_rdata;
            bg_ack_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg   <= ARB_IDLE;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_wait  = cpu_pend_reg | (state_reg == ARB_CPU);
  assign cpu_rdata = cpu_rdata_reg;
  assign bg_ack    = bg_ack_reg;
  assign bg_rdata  = bg_rdata_reg;
  assign mem_req   = mem_req_reg;
  assign mem_addr  = mem_reg.addr;
  assign mem_rnw   = mem_reg.rnw;
  assign mem_wdata = mem_reg.wdata;

`ifndef SYNTHESIS
  cpu_req_while_pending: assert property (@(posedge clk) disable iff (reset) !(cpu_req && cpu_pend_reg))
    else $warning("cpu_req ignored: an access is already pending");
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table-driven single accesses plus
// contention, collision, double-request and mid-access reset sequences.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [26:0] cpu_addr;
  logic        cpu_rnw;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait;
  logic        bg_req;
  logic [26:0] bg_addr;
  logic        bg_rnw;
  logic [7:0]  bg_wdata;
  logic        bg_ack;
  logic [7:0]  bg_rdata;
  logic        mem_req;
  logic [26:0] mem_addr;
  logic        mem_rnw;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_W(27), .BG_MAX_WAIT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .bg_req(bg_req), .bg_addr(bg_addr), .bg_rnw(bg_rnw), .bg_wdata(bg_wdata),
    .bg_ack(bg_ack), .bg_rdata(bg_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rnw(mem_rnw), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_bg;
    logic [26:0] addr;
    logic        rnw;
    logic [7:0]  wdata;
    logic [7:0]  mrdata;
    int          lat;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; cpu_req = 0; cpu_addr = '0; cpu_rnw = 0; cpu_wdata = '0;
    bg_req = 0; bg_addr = '0; bg_rnw = 0; bg_wdata = '0; mem_ack = 0; mem_rdata = '0;

    vecs[0] = '{is_bg: 0, addr: 27'h0001234, rnw: 1, wdata: 8'h00, mrdata: 8'h5A, lat: 3, exp_rdata: 8'h5A};
    vecs[1] = '{is_bg: 1, addr: 27'h4000000, rnw: 0, wdata: 8'hC3, mrdata: 8'h11, lat: 2, exp_rdata: 8'h11};
    vecs[2] = '{is_bg: 0, addr: 27'h7FFFFFF, rnw: 0, wdata: 8'hA5, mrdata: 8'h99, lat: 1, exp_rdata: 8'h5A};
    vecs[3] = '{is_bg: 1, addr: 27'h0000000, rnw: 1, wdata: 8'h00, mrdata: 8'h3C, lat: 0, exp_rdata: 8'h3C};
    vecs[4] = '{is_bg: 0, addr: 27'h2AAAAAA, rnw: 1, wdata: 8'h00, mrdata: 8'hFF, lat: 0, exp_rdata: 8'hFF};

    step(); step();
    chk("reset_mem_req", 32'(mem_req), 0);
    chk("reset_cpu_wait", 32'(cpu_wait), 0);
    chk("reset_bg_ack", 32'(bg_ack), 0);
    chk("reset_outs", {mem_addr, mem_rnw, mem_wdata} | {cpu_rdata, bg_rdata}, 0);
    reset = 1'b0;
    step();

    // Single accesses from the table
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("v%0d_idle_mem_req", i), 32'(mem_req), 0);
      if (vecs[i].is_bg) begin
        bg_req = 1; bg_addr = vecs[i].addr; bg_rnw = vecs[i].rnw; bg_wdata = vecs[i].wdata;
      end else begin
        cpu_req = 1; cpu_addr = vecs[i].addr; cpu_rnw = vecs[i].rnw; cpu_wdata = vecs[i].wdata;
      end
      step();
      cpu_req = 0;
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 1);
      chk($sformatf("v%0d_mem_fields", i), {mem_addr, mem_rnw, mem_wdata},
          {vecs[i].addr, vecs[i].rnw, (vecs[i].rnw ? 8'h00 : vecs[i].wdata)});
      chk($sformatf("v%0d_cpu_wait", i), 32'(cpu_wait), vecs[i].is_bg ? 0 : 1);
      for (int k = 0; k < vecs[i].lat; k++) begin
        step();
        chk($sformatf("v%0d_hold", i), {mem_req, mem_addr}, {1'b1, vecs[i].addr});
      end
      mem_ack = 1; mem_rdata = vecs[i].mrdata;
      step();
      mem_ack = 0; bg_req = 0;
      chk($sformatf("v%0d_req_drop", i), 32'(mem_req), 0);
      chk($sformatf("v%0d_cpu_wait_after", i), 32'(cpu_wait), 0);
      if (vecs[i].is_bg) begin
        chk($sformatf("v%0d_bg_ack", i), 32'(bg_ack), 1);
        chk($sformatf("v%0d_bg_rdata", i), 32'(bg_rdata), 32'(vecs[i].exp_rdata));
      end else begin
        chk($sformatf("v%0d_bg_ack", i), 32'(bg_ack), 0);
        chk($sformatf("v%0d_cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].exp_rdata));
      end
      step();
      chk($sformatf("v%0d_bg_ack_pulse", i), 32'(bg_ack), 0);
      $display("vector %0d: bg=%0d addr=0x%0h done", i, vecs[i].is_bg, vecs[i].addr);
    end

    // Contention: CPU x4, then forced BG, then CPU
    begin
      bit exp_bg[6]  = '{0, 0, 0, 0, 1, 0};
      int exp_cnt[6] = '{1, 2, 3, 4, 0, 1};
      bg_addr = 27'h4000000; bg_rnw = 1; bg_req = 1;
      for (int g = 0; g < 6; g++) begin
        if (!cpu_wait) begin
          cpu_req = 1; cpu_addr = 27'h100 + 27'(g); cpu_rnw = 1;
        end
        step();
        cpu_req = 0;
        chk($sformatf("cont%0d_mem_req", g), 32'(mem_req), 1);
        chk($sformatf("cont%0d_grant_bg", g), 32'(mem_addr == 27'h4000000), 32'(exp_bg[g]));
        chk($sformatf("cont%0d_starve", g), 32'(dut.starve_cnt_reg), 32'(exp_cnt[g]));
        mem_ack = 1; mem_rdata = 8'(g);
        step();
        mem_ack = 0;
        chk($sformatf("cont%0d_bg_ack", g), 32'(bg_ack), 32'(exp_bg[g]));
        $display("contention grant %0d: bg=%0d", g, exp_bg[g]);
      end
      bg_req = 0;
      step();
      chk("cont_starve_clear", 32'(dut.starve_cnt_reg), 0);
    end

    // Collision: cpu_req on the same edge as mem_ack of a BG access
    bg_req = 1; bg_addr = 27'h0ABCDEF; bg_rnw = 1;
    step();
    chk("coll_bg_grant", {mem_req, mem_addr}, {1'b1, 27'h0ABCDEF});
    step();
    mem_ack = 1; mem_rdata = 8'h77; cpu_req = 1; cpu_addr = 27'h0000042; cpu_rnw = 1;
    step();
    mem_ack = 0; cpu_req = 0; bg_req = 0;
    chk("coll_bg_ack", 32'(bg_ack), 1);
    chk("coll_cpu_wait_idle", {cpu_wait, mem_req}, {1'b1, 1'b0});
    step();
    chk("coll_cpu_grant", {mem_req, mem_addr, cpu_wait}, {1'b1, 27'h0000042, 1'b1});
    mem_ack = 1; mem_rdata = 8'h24;
    step();
    mem_ack = 0;
    chk("coll_cpu_done", {cpu_wait, cpu_rdata}, {1'b0, 8'h24});
    $display("collision sequence done");

    // Double cpu_req while pending: A kept, B dropped
    bg_req = 1; bg_addr = 27'h0000777; bg_rnw = 0; bg_wdata = 8'h01;
    step();
    cpu_req = 1; cpu_addr = 27'h000000A; cpu_rnw = 1;
    step();
    cpu_addr = 27'h000000B;
    step();
    cpu_req = 0;
    mem_ack = 1; mem_rdata = 8'h00;
    step();
    mem_ack = 0; bg_req = 0;
    chk("dbl_wait_pending", 32'(cpu_wait), 1);
    step();
    chk("dbl_issue_a", {mem_req, mem_addr}, {1'b1, 27'h000000A});
    mem_ack = 1; mem_rdata = 8'hAB;
    step();
    mem_ack = 0;
    chk("dbl_a_rdata", 32'(cpu_rdata), 32'h0AB);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("dbl_no_b_%0d", k), {mem_req, cpu_wait}, 0);
    end
    $display("double request sequence done");

    // Reset in the middle of a CPU access
    cpu_req = 1; cpu_addr = 27'h0001000; cpu_rnw = 1;
    step();
    cpu_req = 0;
    chk("rst_in_cpu", {mem_req, cpu_wait}, {1'b1, 1'b1});
    reset = 1;
    step();
    reset = 0;
    chk("rst_mem_req", {mem_req, cpu_wait}, 0);
    chk("rst_state", 32'(dut.state_reg), 32'(ARB_IDLE));
    mem_ack = 1; mem_rdata = 8'hEE;
    step();
    mem_ack = 0;
    chk("rst_stray_ack", {mem_req, cpu_wait, bg_ack, cpu_rdata, bg_rdata}, 0);
    $display("reset sequence done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
